// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-RAM load/store initiator: op and state encodings,
// big-endian byte-lane select constants, RAM strobe levels and small op decoders.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLbu = 3'd1,
        OpLh  = 3'd2,
        OpLhu = 3'd3,
        OpLw  = 3'd4,
        OpSb  = 3'd5,
        OpSh  = 3'd6,
        OpSw  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Lane 3 (bits 31:24) holds byte offset 0.
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;
    localparam logic [3:0] SEL_HI   = 4'b1100;
    localparam logic [3:0] SEL_LO   = 4'b0011;
    localparam logic [3:0] SEL_W    = 4'b1111;
    localparam logic [3:0] SEL_NONE = 4'b0000;

    localparam logic CE_ON    = 1'b1;
    localparam logic CE_OFF   = 1'b0;
    localparam logic WE_WRITE = 1'b1;
    localparam logic WE_READ  = 1'b0;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
        case (op)
            OpLh, OpLhu, OpSh: return offset[0];
            OpLw, OpSw:        return offset != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane mapper: lane select and store replication on the request side,
// load extraction with sign/zero extension on the response side (big-endian lanes).
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [3:0]  sel_b;
    logic [3:0]  sel_h;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        sel_b    = SEL_B0;
        byte_val = rdata[31:24];
        unique case (offset)
            2'd0: begin sel_b = SEL_B0; byte_val = rdata[31:24]; end
            2'd1: begin sel_b = SEL_B1; byte_val = rdata[23:16]; end
            2'd2: begin sel_b = SEL_B2; byte_val = rdata[15:8];  end
            2'd3: begin sel_b = SEL_B3; byte_val = rdata[7:0];   end
        endcase
        // offset[0] is deliberately ignored for halfwords.
        sel_h    = offset[1] ? SEL_LO : SEL_HI;
        half_val = offset[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel       = SEL_W;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (op)
            OpLb:  begin sel = sel_b; rdata_ext = {{24{byte_val[7]}}, byte_val}; end
            OpLbu: begin sel = sel_b; rdata_ext = {24'h0, byte_val}; end
            OpLh:  begin sel = sel_h; rdata_ext = {{16{half_val[15]}}, half_val}; end
            OpLhu: begin sel = sel_h; rdata_ext = {16'h0, half_val}; end
            OpSb:  begin sel = sel_b; wdata_rep = {4{wdata[7:0]}}; end
            OpSh:  begin sel = sel_h; wdata_rep = {2{wdata[15:0]}}; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the data RAM (IDLE -> ACCESS -> RESP).
// Define ALIGN_CHECK_EN to reject misaligned half/word accesses with resp_err.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_sel,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              accept;
    logic              misaligned_req;
    logic [3:0]        lane_sel;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;

    assign req_ready  = (state_q == StIdle) && rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;

`ifdef ALIGN_CHECK_EN
    logic err_q;

    assign misaligned_req = is_misaligned(req_op, req_addr[1:0]);
    assign resp_err       = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned_req;
        end
    end
`else
    assign misaligned_req = 1'b0;
    assign resp_err       = 1'b0;
`endif

    mem_lane_align u_lane_align (
        .op        (op_q),
        .offset    (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .sel       (lane_sel),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = misaligned_req ? StResp : StAccess;
            StAccess: state_d = StResp;
            StResp:   if (resp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Strobes only in ACCESS; address and write data hold their last driven values.
    always_comb begin
        mem_ce    = CE_OFF;
        mem_we    = WE_READ;
        mem_sel   = SEL_NONE;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        if (state_q == StAccess) begin
            mem_ce    = CE_ON;
            mem_we    = is_store(op_q) ? WE_WRITE : WE_READ;
            mem_sel   = lane_sel;
            mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            mem_wdata = lane_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            op_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= 32'h0;
            end
            if (state_q == StAccess) begin
                mem_addr_q  <= mem_addr;
                mem_wdata_q <= mem_wdata;
                rdata_q     <= is_store(op_q) ? 32'h0 : lane_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small big-endian byte-enabled RAM model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:63];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_sel    (mem_sel),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            if (mem_sel[3]) ram[mem_addr[7:2]][31:24] <= mem_wdata[31:24];
            if (mem_sel[2]) ram[mem_addr[7:2]][23:16] <= mem_wdata[23:16];
            if (mem_sel[1]) ram[mem_addr[7:2]][15:8]  <= mem_wdata[15:8];
            if (mem_sel[0]) ram[mem_addr[7:2]][7:0]   <= mem_wdata[7:0];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE and resp_ready high.
    task automatic access(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] esel,
                          input logic [31:0] ewdata, input logic [31:0] erdata);
        logic st;
        st = (op == OpSb) || (op == OpSh) || (op == OpSw);
        check({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".ce"}, {31'h0, mem_ce}, 32'h1);
        check({tag, ".we"}, {31'h0, mem_we}, {31'h0, st});
        check({tag, ".sel"}, {28'h0, mem_sel}, {28'h0, esel});
        check({tag, ".addr"}, mem_addr, {addr[31:2], 2'b00});
        if (st) check({tag, ".wdata"}, mem_wdata, ewdata);
        @(negedge clk);
        check({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h1);
        check({tag, ".rdata"}, resp_rdata, erdata);
        check({tag, ".err"}, {31'h0, resp_err}, 32'h0);
        check({tag, ".ce_resp"}, {31'h0, mem_ce}, 32'h0);
        @(negedge clk);
        check({tag, ".idle_valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".idle_sel"}, {28'h0, mem_sel}, 32'h0);
        check({tag, ".addr_hold"}, mem_addr, {addr[31:2], 2'b00});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_op     = OpLw;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst.req_ready", {31'h0, req_ready}, 32'h0);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst.rdata", resp_rdata, 32'h0);
        check("rst.err", {31'h0, resp_err}, 32'h0);
        check("rst.ce_we", {30'h0, mem_ce, mem_we}, 32'h0);
        check("rst.sel", {28'h0, mem_sel}, 32'h0);
        check("rst.addr", mem_addr, 32'h0);
        check("rst.wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        access("sw10", OpSw, 32'h10, 32'h11223344, 4'b1111, 32'h11223344, 32'h0);
        access("lw10", OpLw, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h11223344);
        access("sb13", OpSb, 32'h13, 32'h000000AB, 4'b0001, 32'hABABABAB, 32'h0);
        access("lb13", OpLb, 32'h13, 32'h0, 4'b0001, 32'h0, 32'hFFFFFFAB);
        access("lbu13", OpLbu, 32'h13, 32'h0, 4'b0001, 32'h0, 32'h000000AB);
        access("lbu11", OpLbu, 32'h11, 32'h0, 4'b0100, 32'h0, 32'h00000022);
        access("lb10", OpLb, 32'h10, 32'h0, 4'b1000, 32'h0, 32'h00000011);
        access("sh20", OpSh, 32'h20, 32'h00007F5A, 4'b1100, 32'h7F5A7F5A, 32'h0);
        access("sh22", OpSh, 32'h22, 32'h00008001, 4'b0011, 32'h80018001, 32'h0);
        access("lh22", OpLh, 32'h22, 32'h0, 4'b0011, 32'h0, 32'hFFFF8001);
        access("lhu20", OpLhu, 32'h20, 32'h0, 4'b1100, 32'h0, 32'h00007F5A);
        access("lh10", OpLh, 32'h10, 32'h0, 4'b1100, 32'h0, 32'h00001122);
        check("ram.w10", ram[4], 32'h112233AB);

`ifdef ALIGN_CHECK_EN
        req_op    = OpLw;
        req_addr  = 32'h12;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("lw12.resp_valid", {31'h0, resp_valid}, 32'h1);
        check("lw12.err", {31'h0, resp_err}, 32'h1);
        check("lw12.rdata", resp_rdata, 32'h0);
        check("lw12.ce", {31'h0, mem_ce}, 32'h0);
        @(negedge clk);
        check("lw12.idle", {31'h0, req_ready}, 32'h1);
        check("lw12.ce_after", {31'h0, mem_ce}, 32'h0);
`else
        access("lw12", OpLw, 32'h12, 32'h0, 4'b1111, 32'h0, 32'h112233AB);
`endif

        // Back-pressure: response held, a second request is ignored.
        resp_ready = 1'b0;
        req_op     = OpLw;
        req_addr   = 32'h20;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        @(negedge clk);
        req_op     = OpSw;
        req_addr   = 32'h30;
        req_wdata  = 32'hDEADBEEF;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp.resp_valid", {31'h0, resp_valid}, 32'h1);
            check("bp.rdata", resp_rdata, 32'h7F5A8001);
            check("bp.req_ready", {31'h0, req_ready}, 32'h0);
            check("bp.ce", {31'h0, mem_ce}, 32'h0);
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp.released", {31'h0, resp_valid}, 32'h0);
        check("bp.req_ready", {31'h0, req_ready}, 32'h1);
        check("bp.no_store", ram[12], 32'h0);

        // Reset during the ACCESS cycle of a load.
        req_op    = OpLw;
        req_addr  = 32'h10;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mrst.ce", {31'h0, mem_ce}, 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("mrst.req_ready", {31'h0, req_ready}, 32'h0);
        check("mrst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("mrst.rdata", resp_rdata, 32'h0);
        check("mrst.ce_we", {30'h0, mem_ce, mem_we}, 32'h0);
        check("mrst.sel", {28'h0, mem_sel}, 32'h0);
        check("mrst.addr", mem_addr, 32'h0);
        check("mrst.wdata", mem_wdata, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.no_resp", {31'h0, resp_valid}, 32'h0);
        check("mrst.ready", {31'h0, req_ready}, 32'h1);
        access("lw10b", OpLw, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h112233AB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator for the data RAM: accepts one memory request at a time from the MEM stage and drives the RAM's chip-enable, write-enable, address, byte-select and write-data. It captures read data, then aligns and sign/zero-extends it, and returns a completion response. It sits between the MEM stage and the data RAM, and owns all byte-lane mapping, which is big-endian (lane 3 = data bits 31:24 = byte address offset 0).

## Interface
- ADDR_W, 32, request/memory address width
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  high in IDLE when not in reset
- req_op  in  3  LB, LBU, LH, LHU, LW, SB, SH, SW (encodings in shared defines)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_err  out  1  misaligned access (see Configuration)
- mem_ce, mem_we  out  1 each  RAM chip/write enable
- mem_addr  out  ADDR_W  word-aligned address (bits 1:0 = 0)
- mem_sel  out  4  byte lane select
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  RAM read data, combinational from mem_addr

## Operation
- FSM with three states:
  - IDLE: waits for a request. On req_valid & req_ready, latch op/addr/wdata and go to ACCESS. A misaligned request under ALIGN_CHECK_EN goes straight to RESP with err.
  - ACCESS: exactly one cycle. Drive mem_ce=1, mem_we=1 for stores and 0 for loads, plus mem_addr/mem_sel/mem_wdata. On loads, capture mem_rdata at the end of the cycle. Go to RESP.
  - RESP: resp_valid=1. Hold resp_rdata/resp_err stable until resp_valid & resp_ready, then go to IDLE.
- mem_sel by size and offset:
  - Byte: offset 0..3 maps to 1000, 0100, 0010, 0001.
  - Half: offset 0 maps to 1100, offset 2 to 0011.
  - Word: 1111.
- mem_wdata lane replication: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Load extraction uses the same lane mapping. LB/LH sign-extend; LBU/LHU zero-extend.
- Outside ACCESS, mem_ce=0, mem_we=0, and mem_sel=0000. mem_addr and mem_wdata hold their last values.

## Timing
- Reset: state IDLE. req_ready=0 while rst=0. resp_valid=0, resp_err=0, resp_rdata=0, mem_ce=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0.
- Aligned access: accepted at edge N, ACCESS in cycle N+1, resp_valid from cycle N+2. With resp_ready held high, req_ready returns at N+3. Throughput is one access per 3 cycles.
- Misaligned access with the check enabled: resp_valid at N+1, and no RAM strobe.
- The store write commits at the end-of-ACCESS edge.
- Reset mid-operation: at any sampled rst=0 edge, return to IDLE and clear all state. A store whose ACCESS cycle coincides with that edge may still commit in the RAM; this is accepted.
- req_valid is ignored outside IDLE. resp_ready is ignored outside RESP.
- Back-pressure: RESP holds indefinitely while resp_ready=0.

## Configuration
- ALIGN_CHECK_EN defined:
  - Misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]≠0) set resp_err=1 and resp_rdata=0.
  - No mem_ce pulse is issued.
- ALIGN_CHECK_EN undefined:
  - Halfwords ignore addr[0]; words ignore addr[1:0].
  - The access proceeds normally, and resp_err is tied 0.

## Structure
- Shared defines include file holds:
  - op encodings
  - state encodings
  - sel constants (SEL_B0..SEL_B3, SEL_HI, SEL_LO, SEL_W)
  - ChipEnable/WriteEnable levels
- One sub-module, mem_lane_align: combinational.
  - Inputs: op, addr[1:0], wdata, rdata.
  - Outputs: sel, replicated wdata, extended rdata.
  - Instantiated once and shared by the request and response paths.

## Test plan
- SW addr 0x10, data 0x11223344, then LW 0x10: ACCESS shows sel=1111, we=1. The load returns 0x11223344 at N+2.
- SB 0x13 data 0xAB, then LB 0x13 and LBU 0x13:
  - The store shows sel=0001 and wdata=0xABABABAB.
  - LB returns 0xFFFFFFAB; LBU returns 0x000000AB.
- SH 0x22 data 0x8001, then LH 0x22 and LHU 0x20:
  - The store shows sel=0011.
  - LH returns 0xFFFF8001. LHU returns the upper half, which is previously written.
- With ALIGN_CHECK_EN, LW 0x12: resp_err=1 and rdata=0 at N+1, mem_ce never high. Without the macro, the same request reads word 0x10.
- Hold resp_ready=0 for 5 cycles: resp_valid and rdata stay stable, req_ready=0, and a second req_valid is not accepted.
- Drive rst=0 during ACCESS of a load: the next cycle is IDLE, all outputs are 0, no response is issued, and req_ready=1 after rst returns to 1.
